// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the shared-datapath mux selects, write enables and memory handshake.
// Outputs are Moore decodes of the current state, except for the enables that
// must follow MemReady or BranchTaken in the same cycle.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
        S_JALRLINK = 4'd12, S_LUI      = 4'd13, S_AUIPC  = 4'd14, S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state_q, state_d;

    logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, reg_write_s;
    logic       pc_update_s, branch_s, instr_done_s, illegal_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s, alu_op_s;
    logic [2:0] imm_src_s;

    // State register; reset returns the FSM to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; request states hold until the memory accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRLINK;
            S_JALRLINK: state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src_s = 3'b000;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: imm_src_s = 3'b000;
            OP_STORE:                 imm_src_s = 3'b001;
            OP_BRANCH:                imm_src_s = 3'b010;
            OP_JAL:                   imm_src_s = 3'b011;
            OP_LUI, OP_AUIPC:         imm_src_s = 3'b100;
            default:                  imm_src_s = 3'b000;
        endcase
    end

    // Per-state datapath controls; anything not named in a state stays 0.
    always_comb begin
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        illegal_s    = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        result_src_s = 2'b00;
        alu_op_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = MemReady;
                pc_update_s  = MemReady;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b11;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
            end
            S_JAL, S_JALRLINK: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            S_JALR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_LUI: begin
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
        instr_done_s = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_ILLEGAL);
    end

    // Drive the ports, holding every output at 0 while reset is asserted.
    always_comb begin
        if (rst_n) begin
            MemReq    = mem_req_s;
            MemWrite  = mem_write_s;
            AdrSrc    = adr_src_s;
            IRWrite   = ir_write_s;
            PCWrite   = pc_update_s | (branch_s & BranchTaken);
            RegWrite  = reg_write_s;
            ALUSrcA   = alu_src_a_s;
            ALUSrcB   = alu_src_b_s;
            ResultSrc = result_src_s;
            ImmSrc    = imm_src_s;
            ALUOp     = alu_op_s;
            InstrDone = instr_done_s;
            Illegal   = illegal_s;
            State     = state_q;
        end else begin
            MemReq    = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
            ImmSrc    = 3'b000;
            ALUOp     = 2'b00;
            InstrDone = 1'b0;
            Illegal   = 1'b0;
            State     = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes a
// hand-written expected output vector for every cycle it drives, and an
// independent monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       BranchTaken, MemReady;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic [2:0] ImmSrc;
    logic       InstrDone, Illegal;
    logic [3:0] State;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .BranchTaken(BranchTaken), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .InstrDone(InstrDone),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    // Vector layout: State, {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite},
    // ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, InstrDone, Illegal
    typedef struct {
        logic [22:0] v;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_x;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [22:0] act_s;

    assign act_s = {State, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, InstrDone, Illegal};

    function automatic logic [22:0] mk(input logic [3:0] st, input logic [5:0] en,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] r, input logic [2:0] imm,
                                       input logic [1:0] aop, input logic done,
                                       input logic ill);
        return {st, en, a, b, r, imm, aop, done, ill};
    endfunction

    // Monitor: compare the DUT against the oldest expectation each falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_x = sbq.pop_front();
            n_checks++;
            if (act_s !== mon_x.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", mon_x.tag, act_s, mon_x.v);
            end
        end
    end

    task automatic cyc(input logic rs, input logic [6:0] o, input logic mr, input logic bt,
                       input logic [22:0] e, input string tag);
        @(posedge clk);
        #1;
        rst_n       = rs;
        op          = o;
        MemReady    = mr;
        BranchTaken = bt;
        sbq.push_back('{e, tag});
    endtask

    // Fetch with immediate memory response followed by decode.
    task automatic fetch_dec(input logic [6:0] o, input logic [2:0] imm, input logic bt,
                             input string tag);
        cyc(1'b1, o, 1'b1, bt, mk(4'd0, 6'b100110, 2'b00, 2'b10, 2'b10, imm, 2'b00, 1'b0, 1'b0),
            {tag, "_fetch"});
        cyc(1'b1, o, 1'b1, bt, mk(4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, imm, 2'b00, 1'b0, 1'b0),
            {tag, "_decode"});
    endtask

    task automatic aluwb(input logic [6:0] o, input logic [2:0] imm, input string tag);
        cyc(1'b1, o, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1'b1, 1'b0),
            {tag, "_aluwb"});
    endtask

    logic [22:0] zero_v;

    initial begin
        zero_v      = 23'd0;
        rst_n       = 1'b0;
        op          = 7'd0;
        MemReady    = 1'b0;
        BranchTaken = 1'b0;

        cyc(1'b0, 7'd0, 1'b1, 1'b0, zero_v, "reset");

        // R-type: 0,1,6,8
        fetch_dec(OP_R, 3'b000, 1'b0, "r");
        cyc(1'b1, OP_R, 1'b1, 1'b0, mk(4'd6, 6'b0, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0), "r_execr");
        aluwb(OP_R, 3'b000, "r");

        // lw with a 3-cycle memory stall in MEMREAD
        fetch_dec(OP_LW, 3'b000, 1'b0, "lw");
        cyc(1'b1, OP_LW, 1'b0, 1'b0, mk(4'd2, 6'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "lw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, OP_LW, 1'b0, 1'b0, mk(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "lw_memread_wait");
        cyc(1'b1, OP_LW, 1'b1, 1'b0, mk(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "lw_memread_rdy");
        cyc(1'b1, OP_LW, 1'b1, 1'b0, mk(4'd4, 6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 1'b1, 1'b0), "lw_memwb");

        // sw with fetch stall and one write stall
        for (int i = 0; i < 2; i++)
            cyc(1'b1, OP_SW, 1'b0, 1'b0, mk(4'd0, 6'b100000, 2'b00, 2'b10, 2'b10, 3'b001, 2'b00, 1'b0, 1'b0), "sw_fetch_wait");
        fetch_dec(OP_SW, 3'b001, 1'b0, "sw");
        cyc(1'b1, OP_SW, 1'b1, 1'b0, mk(4'd2, 6'b0, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0), "sw_memadr");
        cyc(1'b1, OP_SW, 1'b0, 1'b0, mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0), "sw_memwrite_wait");
        cyc(1'b1, OP_SW, 1'b1, 1'b0, mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 1'b1, 1'b0), "sw_memwrite_rdy");

        // beq taken, then not taken
        fetch_dec(OP_BEQ, 3'b010, 1'b1, "beq_t");
        cyc(1'b1, OP_BEQ, 1'b1, 1'b1, mk(4'd9, 6'b000010, 2'b10, 2'b00, 2'b00, 3'b010, 2'b01, 1'b1, 1'b0), "beq_t_branch");
        fetch_dec(OP_BEQ, 3'b010, 1'b0, "beq_n");
        cyc(1'b1, OP_BEQ, 1'b1, 1'b0, mk(4'd9, 6'b000000, 2'b10, 2'b00, 2'b00, 3'b010, 2'b01, 1'b1, 1'b0), "beq_n_branch");

        // jalr: 0,1,11,12,8
        fetch_dec(OP_JALR, 3'b000, 1'b0, "jalr");
        cyc(1'b1, OP_JALR, 1'b1, 1'b0, mk(4'd11, 6'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "jalr_jalr");
        cyc(1'b1, OP_JALR, 1'b1, 1'b0, mk(4'd12, 6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "jalr_link");
        aluwb(OP_JALR, 3'b000, "jalr");

        // jal, lui, op-imm, auipc
        fetch_dec(OP_JAL, 3'b011, 1'b0, "jal");
        cyc(1'b1, OP_JAL, 1'b1, 1'b0, mk(4'd10, 6'b000010, 2'b01, 2'b10, 2'b00, 3'b011, 2'b00, 1'b0, 1'b0), "jal_jal");
        aluwb(OP_JAL, 3'b011, "jal");
        fetch_dec(OP_LUI, 3'b100, 1'b0, "lui");
        cyc(1'b1, OP_LUI, 1'b1, 1'b0, mk(4'd13, 6'b0, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0), "lui_lui");
        aluwb(OP_LUI, 3'b100, "lui");
        fetch_dec(OP_IMM, 3'b000, 1'b0, "opimm");
        cyc(1'b1, OP_IMM, 1'b1, 1'b0, mk(4'd7, 6'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0), "opimm_execi");
        aluwb(OP_IMM, 3'b000, "opimm");
        fetch_dec(OP_AUIPC, 3'b100, 1'b0, "auipc");
        cyc(1'b1, OP_AUIPC, 1'b1, 1'b0, mk(4'd14, 6'b0, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0), "auipc_auipc");
        aluwb(OP_AUIPC, 3'b100, "auipc");

        // illegal opcode: stuck with Illegal=1 and no request despite MemReady
        fetch_dec(OP_BAD, 3'b000, 1'b0, "ill");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, OP_BAD, 1'b1, 1'b1, mk(4'd15, 6'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1), "ill_stuck");

        // reset mid-state: outputs drop within the cycle, then fetch resumes
        cyc(1'b0, OP_BAD, 1'b1, 1'b0, zero_v, "rst_mid");
        cyc(1'b0, OP_R, 1'b1, 1'b0, zero_v, "rst_hold");
        fetch_dec(OP_R, 3'b000, 1'b0, "post_rst");
        cyc(1'b1, OP_R, 1'b1, 1'b0, mk(4'd6, 6'b0, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0), "post_rst_execr");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle RV32I core variant. One ALU and one unified instruction/data memory port are shared across cycles.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects, register/IR/PC write enables and the memory request handshake.
- Sits beside the ALU decoder, which consumes ALUOp, and the multicycle datapath.

Parameters:
- None.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from instruction register, Instr[6:0].
- BranchTaken  in  1  branch comparator result for current Instr (funct3 resolved in datapath).
- MemReady  in  1  memory completes current request this cycle.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  request is a write (valid only with MemReq).
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load Instr and OldPC registers.
- PCWrite  out  1  load PC from Result bus.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 memory read data, 10 ALUResult (unregistered).
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  sticky illegal-opcode flag.
- State  out  4  current state encoding, debug/verification.

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11
  - JALRLINK=12, LUI=13, AUIPC=14, ILLEGAL=15
- Reset:
  - rst_n low sets state to FETCH asynchronously.
  - Every output is forced to 0 (State reads 0) while rst_n is low.
  - The first fetch request is issued in the first cycle after deassertion.
- Unlisted outputs are 0 in each state. ALUOut register is written every cycle by the datapath.
- ImmSrc is decoded from op in every state: 0000011/0010011/1100111 give I; 0100011 S; 1100011 B; 1101111 J; 0110111/0010111 U; anything else gives 000.
- PCWrite = PCUpdate | (Branch & BranchTaken). PCUpdate and Branch are internal.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=MemReady and PCUpdate=MemReady.
  - Holds while MemReady=0, with no IR/PC write. Goes to DECODE on MemReady.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01 (precompute OldPC+imm).
  - Next state by op:
    - load or store -> MEMADR
    - R -> EXECR
    - OP-IMM -> EXECI
    - branch -> BRANCH
    - JAL -> JAL
    - JALR -> JALR
    - LUI -> LUI
    - AUIPC -> AUIPC
    - other -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD if op=load, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Holds until MemReady, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 (PC <- OldPC+imm). Goes to ALUWB, which writes OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01 (target into ALUOut). Goes to JALRLINK.
- JALRLINK: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01. Goes to ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01. Goes to ALUWB.
- ILLEGAL: Illegal=1 and all enables 0. Stays until reset.
- InstrDone=1 in every cycle whose next state is FETCH, excluding from FETCH itself and from ILLEGAL.
- MemReq must stay high with stable AdrSrc/MemWrite until MemReady is sampled high.
- MemReady outside a request state is ignored.

Test Plan:
- Reset, op=0110011, MemReady=1 -> State 0,1,6,8,0 with RegWrite=1 only in ALUWB and InstrDone=1 in ALUWB; 4 cycles per instruction.
- lw (op=0000011), MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with MemReq=1 and AdrSrc=1; MEMWB then has ResultSrc=01 and RegWrite=1.
- sw (op=0100011) -> State 0,1,2,5,0; MemWrite=1 only in MEMWRITE; RegWrite never asserted.
- beq with BranchTaken=1, then with 0 -> PCWrite=1 in BRANCH only when taken; ALUOp=01; ImmSrc=010.
- jalr (op=1100111) -> State 0,1,11,12,8,0; PCWrite in JALRLINK; RegWrite in ALUWB.
- op=1111111 -> ILLEGAL with Illegal=1, no MemReq, stuck through 10 cycles. Assert rst_n=0 mid-state -> outputs 0 immediately, then FETCH.
